// File: rtl/muldiv_scheduler.sv
// Sequences one RV32M operation at a time onto the iterative multiplier/divider.
// Divide-by-zero and signed overflow are resolved locally; flush and timeout drain the busy unit.
module muldiv_scheduler #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_rs1_i,
   input  logic [31:0] req_rs2_i,
   input  logic        flush_i,
   output logic        mul_start_o,
   output logic        div_start_o,
   output logic [1:0]  mul_opcode_o,
   output logic [1:0]  div_opcode_o,
   output logic [31:0] operand1_o,
   output logic [31:0] operand2_o,
   input  logic        mul_done_i,
   input  logic        div_done_i,
   input  logic [31:0] mul_result_i,
   input  logic [31:0] div_result_i,
   output logic        stall_o,
   output logic [31:0] result_o,
   output logic        result_valid_o,
   output logic        err_timeout_o
);
   localparam int unsigned DATA_W   = 32;
   localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_BUSY,
      S_DIV_BUSY,
      S_DONE,
      S_DRAIN
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                mul_start_q, mul_start_d;
   logic                div_start_q, div_start_d;
   logic [1:0]          opcode_q, opcode_d;
   logic [DATA_W-1:0]   op1_q, op1_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                result_valid_q, result_valid_d;
   logic                err_timeout_q, err_timeout_d;
   logic                is_div_q, is_div_d;

   logic accept, busy, unit_done, drain_done, timeout_hit, special;

   // Divide cases whose RISC-V result is fixed without running the divider.
   function automatic logic div_is_special(input logic [2:0] f3,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
      return (b == '0) || (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [DATA_W-1:0] div_special_result(input logic [2:0] f3,
                                                            input logic [DATA_W-1:0] a,
                                                            input logic [DATA_W-1:0] b);
      if (b == '0)
         return f3[1] ? a : 32'hFFFF_FFFF;
      return f3[1] ? '0 : 32'h8000_0000;
   endfunction

   assign accept      = (state_q == S_IDLE) && req_valid_i && !flush_i;
   assign special     = req_funct3_i[2] && div_is_special(req_funct3_i, req_rs1_i, req_rs2_i);
   assign busy        = (state_q == S_MUL_BUSY) || (state_q == S_DIV_BUSY);
   assign unit_done   = ((state_q == S_MUL_BUSY) && mul_done_i) ||
                        ((state_q == S_DIV_BUSY) && div_done_i);
   assign drain_done  = (state_q == S_DRAIN) && (is_div_q ? div_done_i : mul_done_i);
   assign timeout_hit = busy && !unit_done && !flush_i && (cnt_q == CNT_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         mul_start_q    <= 1'b0;
         div_start_q    <= 1'b0;
         opcode_q       <= '0;
         op1_q          <= '0;
         op2_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         is_div_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mul_start_q    <= mul_start_d;
         div_start_q    <= div_start_d;
         opcode_q       <= opcode_d;
         op1_q          <= op1_d;
         op2_q          <= op2_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         err_timeout_q  <= err_timeout_d;
         is_div_q       <= is_div_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!req_funct3_i[2])
                  state_d = S_MUL_BUSY;
               else if (special)
                  state_d = S_DONE;
               else
                  state_d = S_DIV_BUSY;
            end
         end
         S_MUL_BUSY, S_DIV_BUSY: begin
            if (unit_done)
               state_d = flush_i ? S_IDLE : S_DONE;
            else if (flush_i || timeout_hit)
               state_d = S_DRAIN;
         end
         S_DONE:  state_d = S_IDLE;
         S_DRAIN: if (drain_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mul_start_d    = 1'b0;
      div_start_d    = 1'b0;
      result_valid_d = 1'b0;
      err_timeout_d  = 1'b0;
      cnt_d          = cnt_q;
      opcode_d       = opcode_q;
      op1_d          = op1_q;
      op2_d          = op2_q;
      result_d       = result_q;
      is_div_d       = is_div_q;
      if (accept) begin
         op1_d    = req_rs1_i;
         op2_d    = req_rs2_i;
         opcode_d = req_funct3_i[1:0];
         is_div_d = req_funct3_i[2];
         cnt_d    = '0;
         if (!req_funct3_i[2]) begin
            mul_start_d = 1'b1;
         end else if (special) begin
            result_d       = div_special_result(req_funct3_i, req_rs1_i, req_rs2_i);
            result_valid_d = 1'b1;
         end else begin
            div_start_d = 1'b1;
         end
      end
      if (busy) begin
         if (unit_done) begin
            if (!flush_i) begin
               result_d       = (state_q == S_MUL_BUSY) ? mul_result_i : div_result_i;
               result_valid_d = 1'b1;
            end
         end else if (timeout_hit) begin
            err_timeout_d = 1'b1;
            result_d      = '0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   assign stall_o        = req_valid_i && (state_q != S_DONE);
   assign result_valid_o = result_valid_q && !flush_i;
   assign mul_start_o    = mul_start_q;
   assign div_start_o    = div_start_q;
   assign mul_opcode_o   = opcode_q;
   assign div_opcode_o   = opcode_q;
   assign operand1_o     = op1_q;
   assign operand2_o     = op2_q;
   assign result_o       = result_q;
   assign err_timeout_o  = err_timeout_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Bench for muldiv_scheduler: directed scenarios with literal expectations, then randomized
// traffic against a transaction-level model and emulated multiplier/divider units.
module tb_muldiv_scheduler;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, flush, mul_done, div_done;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1, req_rs2, mul_result, div_result;
   logic        mul_start, div_start, stall, result_valid, err_timeout;
   logic [1:0]  mul_opcode, div_opcode;
   logic [31:0] operand1, operand2, result;

   always #5 clk = ~clk;

   muldiv_scheduler #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_funct3_i(req_funct3),
      .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .flush_i(flush),
      .mul_start_o(mul_start), .div_start_o(div_start),
      .mul_opcode_o(mul_opcode), .div_opcode_o(div_opcode),
      .operand1_o(operand1), .operand2_o(operand2),
      .mul_done_i(mul_done), .div_done_i(div_done),
      .mul_result_i(mul_result), .div_result_i(div_result),
      .stall_o(stall), .result_o(result), .result_valid_o(result_valid),
      .err_timeout_o(err_timeout)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cmpb(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // RISC-V M-extension result from plain 64-bit arithmetic.
   function automatic logic [31:0] rv32m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f3)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            up = ua / ub; return up[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            up = ua % ub; return up[31:0];
         end
      endcase
   endfunction

   function automatic bit div_trivial(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Model: which unit owns the outstanding op, whether its result is still wanted,
   // whether a result is being presented, and how many busy cycles have elapsed.
   int          m_kind = 0;
   bit          m_live = 1'b0, m_present = 1'b0;
   int          m_age = 0;
   logic [2:0]  m_f3 = '0;
   logic [31:0] m_rs1 = '0, m_rs2 = '0;
   bit          e_ms = 1'b0, e_ds = 1'b0, e_rv = 1'b0, e_err = 1'b0;
   logic [31:0] e_res = '0, e_op1 = '0, e_op2 = '0;
   logic [1:0]  e_opc = '0;
   logic        m_fin;
   assign m_fin = (m_kind == 1) ? mul_done : div_done;

   always @(posedge clk) begin
      if (rst) begin
         m_kind <= 0; m_live <= 1'b0; m_present <= 1'b0; m_age <= 0;
         e_ms <= 1'b0; e_ds <= 1'b0; e_rv <= 1'b0; e_err <= 1'b0;
         e_res <= '0; e_op1 <= '0; e_op2 <= '0; e_opc <= '0;
      end else begin
         e_ms <= 1'b0; e_ds <= 1'b0; e_rv <= 1'b0; e_err <= 1'b0;
         if (m_present) begin
            m_present <= 1'b0;
         end else if (m_kind == 0) begin
            if (req_valid && !flush) begin
               e_op1 <= req_rs1; e_op2 <= req_rs2; e_opc <= req_funct3[1:0];
               m_f3 <= req_funct3; m_rs1 <= req_rs1; m_rs2 <= req_rs2;
               if (!req_funct3[2]) begin
                  m_kind <= 1; m_live <= 1'b1; m_age <= 0; e_ms <= 1'b1;
               end else if (div_trivial(req_funct3, req_rs1, req_rs2)) begin
                  e_res <= rv32m(req_funct3, req_rs1, req_rs2); e_rv <= 1'b1; m_present <= 1'b1;
               end else begin
                  m_kind <= 2; m_live <= 1'b1; m_age <= 0; e_ds <= 1'b1;
               end
            end
         end else if (m_live) begin
            m_age <= m_age + 1;
            if (m_fin) begin
               m_kind <= 0;
               if (!flush) begin
                  e_res <= (m_kind == 1) ? mul_result : div_result;
                  e_rv <= 1'b1; m_present <= 1'b1;
               end
            end else if (flush) begin
               m_live <= 1'b0;
            end else if (m_age + 1 == TO) begin
               m_live <= 1'b0; e_err <= 1'b1; e_res <= '0;
            end
         end else if (m_fin) begin
            m_kind <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cmpb("mul_start", mul_start, e_ms);
         cmpb("div_start", div_start, e_ds);
         cmpb("start_overlap", mul_start & div_start, 1'b0);
         cmpb("result_valid", result_valid, e_rv & !flush);
         cmpb("err_timeout", err_timeout, e_err);
         cmpb("stall", stall, req_valid & !m_present);
         cmp("result", result, e_res);
         cmp("operand1", operand1, e_op1);
         cmp("operand2", operand2, e_op2);
         cmp("mul_opcode", {30'b0, mul_opcode}, {30'b0, e_opc});
         cmp("div_opcode", {30'b0, div_opcode}, {30'b0, e_opc});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      req_valid = 1'b0; flush = 1'b0; mul_done = 1'b0; div_done = 1'b0;
   endtask

   task automatic set_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(1, 9));
         default: return $urandom;
      endcase
   endfunction

   function automatic int lat();
      if ($urandom_range(0, 7) < 6) return $urandom_range(1, 5);
      case ($urandom_range(0, 4))
         0: return 6;
         1: return 7;
         2: return 8;
         3: return 9;
         default: return 12;
      endcase
   endfunction

   int mul_cd = -1, div_cd = -1;
   logic [31:0] mul_val, div_val;
   bit p_req, p_stall, p_flush, p_rst;

   initial begin
      rst = 1'b1; quiet();
      req_funct3 = '0; req_rs1 = '0; req_rs2 = '0; mul_result = '0; div_result = '0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; chk_en = 1'b1;
      @(negedge clk);
      cmpb("reset_result_valid", result_valid, 1'b0);
      cmp("reset_result", result, 32'h0);
      cmp("reset_operand1", operand1, 32'h0);

      // MUL with a 3-cycle unit latency
      tick(); set_req(3'b000, 32'd7, 32'hFFFF_FFFD);
      @(negedge clk); cmpb("t1_stall_accept", stall, 1'b1);
      tick(); @(negedge clk);
      cmpb("t1_mul_start", mul_start, 1'b1);
      cmp("t1_mul_opcode", {30'b0, mul_opcode}, 32'h0);
      cmp("t1_operand2", operand2, 32'hFFFF_FFFD);
      tick(); @(negedge clk); cmpb("t1_start_once", mul_start, 1'b0);
      tick();
      tick(); mul_done = 1'b1; mul_result = 32'hFFFF_FFEB;
      @(negedge clk); cmpb("t1_stall_done", stall, 1'b1);
      tick(); mul_done = 1'b0;
      @(negedge clk);
      cmpb("t1_rv", result_valid, 1'b1);
      cmp("t1_result", result, 32'hFFFF_FFEB);
      cmpb("t1_stall_low", stall, 1'b0);
      tick(); quiet(); @(negedge clk); cmpb("t1_rv_one_cycle", result_valid, 1'b0);

      // Divide by zero, DIV then REMU
      tick(); set_req(3'b100, 32'h1234, 32'h0);
      tick(); @(negedge clk);
      cmpb("t2_no_div_start", div_start, 1'b0);
      cmpb("t2_rv", result_valid, 1'b1);
      cmp("t2_div0", result, 32'hFFFF_FFFF);
      tick(); set_req(3'b111, 32'h1234, 32'h0);
      tick(); @(negedge clk);
      cmp("t2_remu0", result, 32'h1234);

      // Signed overflow, DIV then REM
      tick(); set_req(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      tick(); @(negedge clk);
      cmpb("t3_no_div_start", div_start, 1'b0);
      cmp("t3_div_ovf", result, 32'h8000_0000);
      tick(); set_req(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      tick(); @(negedge clk);
      cmpb("t3_rv", result_valid, 1'b1);
      cmp("t3_rem_ovf", result, 32'h0);
      tick(); quiet();

      // DIVU flushed mid-flight, MUL waits in DRAIN
      tick(); set_req(3'b101, 32'd100, 32'd7);
      tick(); @(negedge clk);
      cmpb("t4_div_start", div_start, 1'b1);
      cmp("t4_div_opcode", {30'b0, div_opcode}, 32'h1);
      tick();
      tick(); flush = 1'b1;
      tick(); flush = 1'b0; set_req(3'b000, 32'd3, 32'd5);
      repeat (3) tick();
      @(negedge clk); cmpb("t4_stall_drain", stall, 1'b1);
      tick(); div_done = 1'b1; div_result = 32'd14;
      @(negedge clk); cmpb("t4_no_rv", result_valid, 1'b0);
      tick(); div_done = 1'b0;
      @(negedge clk); cmpb("t4_accept_cycle", mul_start, 1'b0);
      tick(); @(negedge clk); cmpb("t4_mul_start", mul_start, 1'b1);
      tick(); mul_done = 1'b1; mul_result = 32'd15;
      tick(); mul_done = 1'b0;
      @(negedge clk); cmp("t4_result", result, 32'd15);
      tick(); quiet();

      // Timeout with TIMEOUT=8, then late done, then MULHU and REM back to back
      tick(); set_req(3'b000, 32'd9, 32'd9);
      repeat (8) tick();
      @(negedge clk); cmpb("t5_no_err_yet", err_timeout, 1'b0);
      tick(); flush = 1'b1;
      @(negedge clk);
      cmpb("t5_err", err_timeout, 1'b1);
      cmp("t5_result0", result, 32'h0);
      tick(); quiet();
      @(negedge clk); cmpb("t5_err_pulse", err_timeout, 1'b0);
      tick(); set_req(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick(); mul_done = 1'b1; mul_result = 32'hDEAD_BEEF;
      @(negedge clk); cmpb("t5_late_done_stall", stall, 1'b1);
      tick(); mul_done = 1'b0;
      tick(); @(negedge clk); cmpb("t6_mul_start", mul_start, 1'b1);
      tick(); mul_done = 1'b1; mul_result = 32'hFFFF_FFFE;
      tick(); mul_done = 1'b0;
      @(negedge clk); cmp("t6_mulhu", result, 32'hFFFF_FFFE);
      tick(); set_req(3'b110, 32'hFFFF_FFF9, 32'd2);
      @(negedge clk); cmpb("t6_gap", result_valid, 1'b0);
      tick(); @(negedge clk); cmpb("t6_div_start", div_start, 1'b1);
      tick();
      tick(); div_done = 1'b1; div_result = 32'hFFFF_FFFF;
      tick(); div_done = 1'b0;
      @(negedge clk);
      cmpb("t6_rv", result_valid, 1'b1);
      cmp("t6_rem", result, 32'hFFFF_FFFF);
      tick(); quiet();

      // Reset during DIV_BUSY
      tick(); set_req(3'b100, 32'd50, 32'd5);
      tick();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0; quiet();
      @(negedge clk);
      cmpb("t7_div_start", div_start, 1'b0);
      cmpb("t7_stall", stall, 1'b0);
      cmp("t7_result", result, 32'h0);
      cmp("t7_operand1", operand1, 32'h0);
      cmp("t7_operand2", operand2, 32'h0);
      cmp("t7_opcode", {30'b0, div_opcode}, 32'h0);

      // Randomized traffic with emulated units
      p_req = 1'b0; p_stall = 1'b0; p_flush = 1'b0; p_rst = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         tick();
         rst = ($urandom_range(0, 199) == 0);
         if (!(p_req && p_stall && !p_flush && !p_rst)) begin
            req_valid  = ($urandom_range(0, 9) < 6);
            req_funct3 = 3'($urandom_range(0, 7));
            req_rs1    = pick();
            req_rs2    = pick();
         end
         flush = ($urandom_range(0, 11) == 0);
         mul_done = 1'b0; div_done = 1'b0;
         if (mul_cd > 0) begin
            mul_cd--;
            if (mul_cd == 0) begin mul_done = 1'b1; mul_result = mul_val; mul_cd = -1; end
         end else if (m_kind != 1 && $urandom_range(0, 19) == 0) begin
            mul_done = 1'b1; mul_result = $urandom;
         end
         if (div_cd > 0) begin
            div_cd--;
            if (div_cd == 0) begin div_done = 1'b1; div_result = div_val; div_cd = -1; end
         end else if (m_kind != 2 && $urandom_range(0, 19) == 0) begin
            div_done = 1'b1; div_result = $urandom;
         end
         if (rst) begin mul_cd = -1; div_cd = -1; end
         @(negedge clk);
         p_req = req_valid; p_stall = stall; p_flush = flush; p_rst = rst;
         if (mul_start && !rst) begin mul_cd = lat(); mul_val = rv32m(m_f3, m_rs1, m_rs2); end
         if (div_start && !rst) begin div_cd = lat(); div_val = rv32m(m_f3, m_rs1, m_rs2); end
      end

      tick(); rst = 1'b0; quiet();
      repeat (3) tick();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
